fwd_prop_engine: RTL and testbench
==================================

FWD_PROP_ENGINE -- requirements
Module: fwd_prop_engine

Interface
REQ-001 Parameter N_IN, default 9, input-layer width (samples per inference).
REQ-002 Parameter N_HID, default 5, hidden-neuron count.
REQ-003 Parameter N_OUT, default 4, output-neuron (action) count.
REQ-004 Parameter DW, default 16, signed fixed-point data width.
REQ-005 Parameter FRAC, default 10, fractional bits (Q6.10 at defaults).
REQ-006 Port clk, input, 1, sole clock; all state changes on rising edge.
REQ-007 Port rst, input, 1, reset, asynchronous, active-high.
REQ-008 Port in_valid / in_ready / in_data, input / output / input, 1 / 1 / DW: input-sample stream, handshake when both valid and ready are high.
REQ-009 Port act_mode, input, 2: hidden activation, 0=ReLU, 1=leaky ReLU, 2=identity, 3=reserved (treated as identity); sampled on the first accepted sample.
REQ-010 Port wgt_we / wgt_addr / wgt_data, input, 1 / clog2(NPAR) / DW: parameter write port, NPAR=N_IN*N_HID+N_HID+N_HID*N_OUT+N_OUT.
REQ-011 Port wgt_err, output, 1: one-cycle pulse on a rejected write.
REQ-012 Port a2_out, output, N_HID*DW: hidden activations, neuron j at bits [j*DW +: DW].
REQ-013 Port q_out, output, N_OUT*DW: output-layer values, same packing.
REQ-014 Port q_argmax, output, clog2(N_OUT): index of the largest q_out.
REQ-015 Port out_valid / out_ready, output / input, 1 / 1: result handshake.
REQ-016 Port busy, output, 1: high in every state except IDLE.

Function
REQ-017 Address map: W2[i][j] at i*N_HID+j; B2[j] next; W3[j][k] at base+j*N_OUT+k; B3[k] last.
REQ-018 Writes accepted only in IDLE with addr<NPAR, taking effect next cycle; otherwise ignored, with wgt_err pulsed the following cycle.
REQ-019 States: IDLE, L2, ACT2, L3, ACT3, DONE.
REQ-020 IDLE: in_ready=1; first accepted sample initialises hidden accumulators to B2[j]<<FRAC, adds in_data*W2[0][j], sets the sample counter to 1, and moves to L2.
REQ-021 L2: in_ready=1; each accepted sample i adds in_data*W2[i][j] to all N_HID accumulators in parallel; after sample N_IN-1 the FSM moves to ACT2; no transfer means hold.
REQ-022 ACT2 (1 cycle): a2[j] = act(sat(acc>>>FRAC)) registered; output accumulators initialised to B3[k]<<FRAC; FSM moves to L3.
REQ-023 L3: counter j steps 0..N_HID-1, one per cycle; each step adds a2[j]*W3[j][k] to all N_OUT accumulators; after j=N_HID-1 the FSM moves to ACT3.
REQ-024 ACT3 (1 cycle): q[k] = sat(acc>>>FRAC) registered along with argmax; FSM moves to DONE.
REQ-025 DONE: out_valid=1 with a2_out, q_out and q_argmax stable; on out_ready the FSM returns to IDLE; in_ready=0.
REQ-026 Latency: with in_valid held high, out_valid rises N_IN+N_HID+2 cycles after the first accept edge.
REQ-027 Products are full 2*DW; accumulators are 2*DW+clog2(max(N_IN,N_HID))+1 bits with no intermediate overflow.
REQ-028 >>> is an arithmetic shift (floor); sat clamps the result to [-2^(DW-1), 2^(DW-1)-1].
REQ-029 Leaky ReLU gives x for x>=0, else x>>>3; ReLU gives max(x,0).
REQ-030 Argmax is a signed compare; ties resolve to the lowest index.
REQ-031 Output layer has no activation (Q-values).
REQ-032 a2_out/q_out/q_argmax hold their last values until the next ACT2/ACT3 updates them.

Reset
REQ-033 rst forces IDLE immediately, from any state, including mid-L2/L3.
REQ-034 rst clears counters, accumulators, all weights/biases, a2_out, q_out, q_argmax, out_valid, wgt_err and busy to 0; in_ready=1 after release.

Structure
REQ-035 Package fwd_prop_pkg holds the state enum, act_mode constants, the sat function and the address-base constants.
REQ-036 One sub-module, fp_act_unit (sat + activation, combinational, mode input), instantiated per hidden neuron and per output neuron with mode fixed to identity.

Verification
REQ-037 Defaults; all W2=0x0400, B2=0, W3=0x0100 (0.25), B3[k]=k*0x0400, 9 inputs of 0x0400 -> a2 all 0x2400; q = {0x2D00,0x3100,0x3500,0x3900}; argmax=3; out_valid at cycle 16.
REQ-038 W3=0x0400 with the above -> sum 45.0 saturates: q all 0x7FFF; argmax=0 (tie).
REQ-039 Inputs 0xFC00 (-1.0) with W2=0x0400: act_mode 0 -> a2=0x0000; mode 1 -> a2=0xFB80 (-1.125); mode 2 -> 0xDC00.
REQ-040 in_valid toggling 1/0 -> result identical to REQ-037, latency extended by the stall count.
REQ-041 wgt_we during L3, and addr=NPAR in IDLE -> wgt_err pulse, weights unchanged, result unaffected.
REQ-042 rst asserted mid-L3 -> busy=0 and q_out=0 in the same cycle; the next job with reloaded weights matches REQ-037.

Source files
------------

// File: rtl/fwd_prop_pkg.sv
// rtl/fwd_prop_pkg.sv - shared types, constants and helpers for the forward-propagation engine
package fwd_prop_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_L2,
    S_ACT2,
    S_L3,
    S_ACT3,
    S_DONE
  } state_t;

  localparam logic [1:0] ACT_RELU  = 2'd0;
  localparam logic [1:0] ACT_LEAKY = 2'd1;
  localparam logic [1:0] ACT_IDENT = 2'd2;
  localparam logic [1:0] ACT_RSVD  = 2'd3;

  // Parameter memory layout: W2 row-major, then B2, then W3 row-major, then B3.
  function automatic int b2_base(input int n_in, input int n_hid);
    return n_in * n_hid;
  endfunction

  function automatic int w3_base(input int n_in, input int n_hid);
    return n_in * n_hid + n_hid;
  endfunction

  function automatic int b3_base(input int n_in, input int n_hid, input int n_out);
    return w3_base(n_in, n_hid) + n_hid * n_out;
  endfunction

  function automatic int npar(input int n_in, input int n_hid, input int n_out);
    return b3_base(n_in, n_hid, n_out) + n_out;
  endfunction

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Clamp to the signed range of a dw-bit word; result still 64 bits wide.
  function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/fwd_prop_engine_if.sv
// rtl/fwd_prop_engine_if.sv - sample, parameter-write and result signals of the engine
interface fwd_prop_engine_if #(
  parameter int N_IN  = 9,
  parameter int N_HID = 5,
  parameter int N_OUT = 4,
  parameter int DW    = 16
);
  import fwd_prop_pkg::*;

  localparam int NPAR = npar(N_IN, N_HID, N_OUT);
  localparam int AW   = clog2_min1(NPAR);
  localparam int QW   = clog2_min1(N_OUT);

  logic                   in_valid;
  logic                   in_ready;
  logic [DW-1:0]          in_data;
  logic [1:0]             act_mode;
  logic                   wgt_we;
  logic [AW-1:0]          wgt_addr;
  logic [DW-1:0]          wgt_data;
  logic                   wgt_err;
  logic [N_HID*DW-1:0]    a2_out;
  logic [N_OUT*DW-1:0]    q_out;
  logic [QW-1:0]          q_argmax;
  logic                   out_valid;
  logic                   out_ready;
  logic                   busy;

  modport master (
    output in_valid, in_data, act_mode, wgt_we, wgt_addr, wgt_data, out_ready,
    input  in_ready, wgt_err, a2_out, q_out, q_argmax, out_valid, busy
  );

  modport slave (
    input  in_valid, in_data, act_mode, wgt_we, wgt_addr, wgt_data, out_ready,
    output in_ready, wgt_err, a2_out, q_out, q_argmax, out_valid, busy
  );

endinterface

// File: rtl/fp_act_unit.sv
// rtl/fp_act_unit.sv - rescale an accumulator to DW bits with saturation, then apply activation
module fp_act_unit
  import fwd_prop_pkg::*;
#(
  parameter int ACCW = 37,
  parameter int DW   = 16,
  parameter int FRAC = 10
) (
  input  logic signed [ACCW-1:0] acc,
  input  logic [1:0]             mode,
  output logic signed [DW-1:0]   y
);

  logic signed [63:0]   scaled;
  logic signed [DW-1:0] x;

  always_comb begin
    scaled = 64'(acc >>> FRAC);
    x      = DW'(sat(scaled, DW));
    y      = x;
    case (mode)
      ACT_RELU:            y = x[DW-1] ? '0 : x;
      ACT_LEAKY:           y = x[DW-1] ? (x >>> 3) : x;
      ACT_IDENT, ACT_RSVD: y = x;
      default:             y = x;
    endcase
  end

endmodule

// File: rtl/fwd_prop_engine.sv
// rtl/fwd_prop_engine.sv - two-layer fixed-point MLP inference: streamed hidden layer, serial output layer
module fwd_prop_engine
  import fwd_prop_pkg::*;
#(
  parameter int N_IN  = 9,
  parameter int N_HID = 5,
  parameter int N_OUT = 4,
  parameter int DW    = 16,
  parameter int FRAC  = 10
) (
  input logic clk,
  input logic rst,
  fwd_prop_engine_if.slave bus
);

  localparam int NPAR    = npar(N_IN, N_HID, N_OUT);
  localparam int AW      = clog2_min1(NPAR);
  localparam int QW      = clog2_min1(N_OUT);
  localparam int MAXN    = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int CW      = clog2_min1(MAXN);
  localparam int PW      = 2 * DW;
  localparam int ACCW    = 2 * DW + $clog2(MAXN) + 1;
  localparam int B2_BASE = b2_base(N_IN, N_HID);
  localparam int W3_BASE = w3_base(N_IN, N_HID);
  localparam int B3_BASE = b3_base(N_IN, N_HID, N_OUT);

  state_t                state, next_state;
  logic [CW-1:0]         cnt;
  logic [1:0]            mode;
  logic                  err_q;
  logic [QW-1:0]         amax_q, amax_next;
  logic signed [DW-1:0]  wmem   [NPAR];
  logic signed [ACCW-1:0] acc_h [N_HID];
  logic signed [ACCW-1:0] acc_o [N_OUT];
  logic signed [DW-1:0]  a2_q   [N_HID];
  logic signed [DW-1:0]  a2_next[N_HID];
  logic signed [DW-1:0]  q_q    [N_OUT];
  logic signed [DW-1:0]  q_next [N_OUT];
  logic signed [DW-1:0]  w2_sel [N_HID];
  logic signed [DW-1:0]  w3_sel [N_OUT];
  logic signed [DW-1:0]  a2_sel;
  logic signed [DW-1:0]  best;
  logic signed [PW-1:0]  prod_h [N_HID];
  logic signed [PW-1:0]  prod_o [N_OUT];
  int                    row_in, row_h;
  logic                  take, wr_ok, last_in, last_hid;

  assign take     = bus.in_valid && (state == S_IDLE || state == S_L2);
  assign wr_ok    = bus.wgt_we && (state == S_IDLE) && (32'(bus.wgt_addr) < NPAR);
  assign last_in  = (int'(cnt) == N_IN - 1);
  assign last_hid = (int'(cnt) == N_HID - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    case (state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (take) next_state = (N_IN == 1) ? S_ACT2 : S_L2;
      end
      S_L2: begin
        bus.in_ready = 1'b1;
        if (take && last_in) next_state = S_ACT2;
      end
      S_ACT2:  next_state = S_L3;
      S_L3:    if (last_hid) next_state = S_ACT3;
      S_ACT3:  next_state = S_DONE;
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Row selects are clamped so idle states never address past the parameter memory.
  always_comb begin
    row_in = 0;
    row_h  = 0;
    if (state == S_L2 && int'(cnt) < N_IN)  row_in = int'(cnt);
    if (state == S_L3 && int'(cnt) < N_HID) row_h  = int'(cnt);
    a2_sel = a2_q[0];
    for (int j = 0; j < N_HID; j++) begin
      w2_sel[j] = wmem[AW'(row_in * N_HID + j)];
      prod_h[j] = PW'($signed(bus.in_data)) * PW'(w2_sel[j]);
      if (row_h == j) a2_sel = a2_q[j];
    end
    for (int k = 0; k < N_OUT; k++) begin
      w3_sel[k] = wmem[AW'(W3_BASE + row_h * N_OUT + k)];
      prod_o[k] = PW'(a2_sel) * PW'(w3_sel[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      mode   <= ACT_RELU;
      err_q  <= 1'b0;
      amax_q <= '0;
      for (int a = 0; a < NPAR; a++) wmem[a] <= '0;
      for (int j = 0; j < N_HID; j++) begin
        acc_h[j] <= '0;
        a2_q[j]  <= '0;
      end
      for (int k = 0; k < N_OUT; k++) begin
        acc_o[k] <= '0;
        q_q[k]   <= '0;
      end
    end else begin
      err_q <= bus.wgt_we && !wr_ok;
      if (wr_ok) wmem[bus.wgt_addr] <= bus.wgt_data;
      case (state)
        S_IDLE: if (take) begin
          mode <= bus.act_mode;
          cnt  <= (N_IN == 1) ? '0 : CW'(1);
          for (int j = 0; j < N_HID; j++)
            acc_h[j] <= (ACCW'(wmem[AW'(B2_BASE + j)]) <<< FRAC) + ACCW'(prod_h[j]);
        end
        S_L2: if (take) begin
          cnt <= last_in ? '0 : cnt + CW'(1);
          for (int j = 0; j < N_HID; j++)
            acc_h[j] <= acc_h[j] + ACCW'(prod_h[j]);
        end
        S_ACT2: begin
          cnt <= '0;
          for (int j = 0; j < N_HID; j++) a2_q[j] <= a2_next[j];
          for (int k = 0; k < N_OUT; k++)
            acc_o[k] <= ACCW'(wmem[AW'(B3_BASE + k)]) <<< FRAC;
        end
        S_L3: begin
          cnt <= last_hid ? '0 : cnt + CW'(1);
          for (int k = 0; k < N_OUT; k++)
            acc_o[k] <= acc_o[k] + ACCW'(prod_o[k]);
        end
        S_ACT3: begin
          for (int k = 0; k < N_OUT; k++) q_q[k] <= q_next[k];
          amax_q <= amax_next;
        end
        default: ;
      endcase
    end
  end

  for (genvar j = 0; j < N_HID; j++) begin : g_hid
    fp_act_unit #(.ACCW(ACCW), .DW(DW), .FRAC(FRAC)) u_act (
      .acc  (acc_h[j]),
      .mode (mode),
      .y    (a2_next[j])
    );
    assign bus.a2_out[j*DW +: DW] = a2_q[j];
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    fp_act_unit #(.ACCW(ACCW), .DW(DW), .FRAC(FRAC)) u_act (
      .acc  (acc_o[k]),
      .mode (ACT_IDENT),
      .y    (q_next[k])
    );
    assign bus.q_out[k*DW +: DW] = q_q[k];
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    amax_next = '0;
    best      = q_next[0];
    for (int k = 1; k < N_OUT; k++) begin
      if (q_next[k] > best) begin
        best      = q_next[k];
        amax_next = QW'(k);
      end
    end
  end

  assign bus.q_argmax = amax_q;
  assign bus.wgt_err  = err_q;

endmodule

// File: tb/tb_fwd_prop_engine.sv
// tb/tb_fwd_prop_engine.sv - directed and randomized checks of fwd_prop_engine against an arithmetic model
module tb_fwd_prop_engine;
  localparam int N_IN  = 9;
  localparam int N_HID = 5;
  localparam int N_OUT = 4;
  localparam int DW    = 16;
  localparam int FRAC  = 10;
  localparam int B2B   = N_IN * N_HID;
  localparam int W3B   = B2B + N_HID;
  localparam int B3B   = W3B + N_HID * N_OUT;
  localparam int NPAR  = B3B + N_OUT;
  localparam int AW    = $clog2(NPAR);
  localparam int LAT   = N_IN + N_HID + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fwd_prop_engine_if #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .DW(DW)) bus ();

  fwd_prop_engine #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .DW(DW), .FRAC(FRAC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int w [NPAR];
  int x [N_IN];
  logic [N_HID*DW-1:0] exp_a2;
  logic [N_OUT*DW-1:0] exp_q;
  int                  exp_am;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic longint clampw(input longint v);
    longint hi, lo;
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -(longint'(1) << (DW - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Whole-network evaluation straight from the real-valued definition.
  task automatic model(input int mode);
    longint acc, v, bestv;
    longint a2m [N_HID];
    longint qm  [N_OUT];
    for (int j = 0; j < N_HID; j++) begin
      acc = longint'(w[B2B + j]) * (longint'(1) << FRAC);
      for (int i = 0; i < N_IN; i++) acc += longint'(x[i]) * w[i * N_HID + j];
      v = clampw(fdiv(acc, longint'(1) << FRAC));
      if (v < 0 && mode == 0) v = 0;
      else if (v < 0 && mode == 1) v = fdiv(v, 8);
      a2m[j] = v;
      exp_a2[j*DW +: DW] = v[DW-1:0];
    end
    for (int k = 0; k < N_OUT; k++) begin
      acc = longint'(w[B3B + k]) * (longint'(1) << FRAC);
      for (int j = 0; j < N_HID; j++) acc += a2m[j] * w[W3B + j * N_OUT + k];
      qm[k] = clampw(fdiv(acc, longint'(1) << FRAC));
      exp_q[k*DW +: DW] = qm[k][DW-1:0];
    end
    exp_am = 0;
    bestv  = qm[0];
    for (int k = 1; k < N_OUT; k++) if (qm[k] > bestv) begin bestv = qm[k]; exp_am = k; end
  endtask

  task automatic wr(input int a, input int d);
    bus.wgt_we   = 1'b1;
    bus.wgt_addr = AW'(a);
    bus.wgt_data = DW'(d);
    @(posedge clk); #1;
    bus.wgt_we   = 1'b0;
  endtask

  task automatic load_all();
    for (int a = 0; a < NPAR; a++) wr(a, w[a]);
  endtask

  task automatic set_base(input int w3v);
    for (int a = 0; a < B2B; a++) w[a] = 'h0400;
    for (int j = 0; j < N_HID; j++) w[B2B + j] = 0;
    for (int a = W3B; a < B3B; a++) w[a] = w3v;
    for (int k = 0; k < N_OUT; k++) w[B3B + k] = k * 'h0400;
  endtask

  task automatic run_job(input int mode, input bit stall, input bit poke, input bit abort, input string tag);
    int idx, cyc, first, stalls, wc;
    bit acc;
    model(mode);
    idx = 0; cyc = 0; first = 0; stalls = 0;
    bus.act_mode = 2'(mode);
    while (idx < N_IN && cyc < 200) begin
      bus.in_valid = stall ? (cyc % 2 == 0) : 1'b1;
      bus.in_data  = DW'(x[idx]);
      acc = bus.in_valid && bus.in_ready;
      if (first > 0 && !acc) stalls++;
      @(posedge clk); #1; cyc++;
      if (acc) begin
        if (first == 0) begin
          first = cyc;
          bus.act_mode = 2'(mode ^ 1);
        end
        idx++;
      end
    end
    bus.in_valid = 1'b0;
    wc = 0;
    while (!bus.out_valid && cyc < 400) begin
      if (poke && wc == 1) begin
        bus.wgt_we = 1'b1; bus.wgt_addr = '0; bus.wgt_data = 16'h7777;
      end
      @(posedge clk); #1; cyc++; wc++;
      if (poke && wc == 2) begin
        bus.wgt_we = 1'b0;
        chk({tag, "_err_busy"}, bus.wgt_err, 1);
      end
      if (poke && wc == 3) chk({tag, "_err_drop"}, bus.wgt_err, 0);
      if (abort && wc == 2) begin
        rst = 1'b1; #1;
        chk({tag, "_rst_busy"}, bus.busy, 0);
        chk({tag, "_rst_q"}, bus.q_out, 0);
        chk({tag, "_rst_a2"}, bus.a2_out, 0);
        chk({tag, "_rst_am"}, bus.q_argmax, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk({tag, "_rst_ready"}, bus.in_ready, 1);
        return;
      end
    end
    chk({tag, "_lat"}, cyc - first + 1, LAT + stalls);
    chk({tag, "_a2"}, bus.a2_out, exp_a2);
    chk({tag, "_q"}, bus.q_out, exp_q);
    chk({tag, "_am"}, bus.q_argmax, exp_am);
    @(posedge clk); #1;
    chk({tag, "_done_hold"}, bus.out_valid, 1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_ov_drop"}, bus.out_valid, 0);
    chk({tag, "_idle"}, bus.busy, 0);
    chk({tag, "_q_hold"}, bus.q_out, exp_q);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.act_mode = '0;
    bus.wgt_we = 1'b0; bus.wgt_addr = '0; bus.wgt_data = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_ov", bus.out_valid, 0);
    chk("rst_q", bus.q_out, 0);
    chk("rst_a2", bus.a2_out, 0);
    chk("rst_err", bus.wgt_err, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", bus.in_ready, 1);

    set_base('h0100);
    for (int i = 0; i < N_IN; i++) x[i] = 'h0400;
    load_all();
    chk("wr_ok_err", bus.wgt_err, 0);
    run_job(0, 0, 0, 0, "base");
    chk("base_q_lit", bus.q_out, 64'h3900_3500_3100_2D00);
    chk("base_a2_lit", bus.a2_out, {5{16'h2400}});
    chk("base_am_lit", bus.q_argmax, 3);

    run_job(0, 1, 0, 0, "stall");
    chk("stall_q_lit", bus.q_out, 64'h3900_3500_3100_2D00);

    wr(NPAR, 'h1234);
    chk("oob_err", bus.wgt_err, 1);
    @(posedge clk); #1;
    chk("oob_err_drop", bus.wgt_err, 0);
    run_job(0, 0, 1, 0, "poke");
    chk("poke_q_lit", bus.q_out, 64'h3900_3500_3100_2D00);

    set_base('h0400);
    load_all();
    run_job(0, 0, 0, 0, "satq");
    chk("sat_q_lit", bus.q_out, {4{16'h7FFF}});
    chk("sat_am_lit", bus.q_argmax, 0);

    set_base('h0100);
    load_all();
    for (int i = 0; i < N_IN; i++) x[i] = -'h0400;
    run_job(0, 0, 0, 0, "neg_relu");
    chk("relu_a2_lit", bus.a2_out, {5{16'h0000}});
    run_job(1, 0, 0, 0, "neg_leaky");
    chk("leaky_a2_lit", bus.a2_out, {5{16'hFB80}});
    run_job(2, 0, 0, 0, "neg_ident");
    chk("ident_a2_lit", bus.a2_out, {5{16'hDC00}});
    run_job(3, 0, 0, 0, "neg_rsvd");

    for (int i = 0; i < N_IN; i++) x[i] = 'h0400;
    run_job(0, 0, 0, 1, "abort");
    load_all();
    run_job(0, 0, 0, 0, "reload");
    chk("reload_q_lit", bus.q_out, 64'h3900_3500_3100_2D00);

    for (int t = 0; t < 6; t++) begin
      int span;
      span = (t < 4) ? 1024 : 8192;
      for (int a = 0; a < NPAR; a++) w[a] = int'($urandom_range(0, 2 * span - 1)) - span;
      for (int i = 0; i < N_IN; i++) x[i] = int'($urandom_range(0, 8191)) - 4096;
      load_all();
      run_job(int'($urandom_range(0, 3)), t[0], 0, 0, $sformatf("rnd%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
